// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated load/store responder for the CPU data-memory port.
// Optional build macro: DMEM_ALIGN_CHECK_EN (reject misaligned half/word accesses with err_o).
module dmem_responder #(
    parameter int WAIT_STATES     = 2,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [2:0]            funct3_i,
    output logic                  ready_o,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic SKIP_WAIT = (WAIT_STATES == 0);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEM_DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;

    // Request captured at accept; consumed when the FSM enters RESP.
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [2:0]            req_funct3;

    logic [31:0] mem [MEM_DEPTH_WORDS];

    logic accept;
    logic enter_resp;
    logic commit;

    // With zero wait states the request enters RESP on its accept edge, so the
    // operands come straight from the port while IDLE.
    logic                  op_we;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [31:0]           op_wdata;
    logic [2:0]            op_funct3;

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic [1:0]            lane;
    logic                  funct3_bad;
    logic                  range_bad;
    logic                  misalign;
    logic                  access_err;
    logic [3:0]            byte_en;
    logic [31:0]           wr_lanes;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_val;

    assign ready_o  = (state == IDLE);
    assign busy_o   = (state != IDLE);
    assign rvalid_o = (state == RESP);
    assign accept   = (state == IDLE) && req_i;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (req_i) begin
                    if (SKIP_WAIT) begin
                        state_next = RESP;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP);
    // rst gates the write so an IDLE->RESP path during reset cannot touch memory.
    assign commit     = enter_resp && !rst;

    always_comb begin
        if (state == IDLE) begin
            op_we     = we_i;
            op_addr   = addr_i;
            op_wdata  = wdata_i;
            op_funct3 = funct3_i;
        end else begin
            op_we     = req_we;
            op_addr   = req_addr;
            op_wdata  = req_wdata;
            op_funct3 = req_funct3;
        end
    end

    assign word_idx = op_addr[ADDR_WIDTH-1:2];
    assign mem_idx  = word_idx[IDX_W-1:0];

    always_comb begin
        funct3_bad = (op_funct3 == 3'b011) || (op_funct3[2:1] == 2'b11) ||
                     (op_we && op_funct3[2]);
        range_bad  = ({2'b00, word_idx} >= DEPTH_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
        misalign   = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                     ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
`else
        misalign   = 1'b0;
`endif
        access_err = funct3_bad || range_bad || misalign;
    end

    // Halves and words are forced onto their natural boundary.
    always_comb begin
        case (op_funct3[1:0])
            2'b00:   lane = op_addr[1:0];
            2'b01:   lane = {op_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = op_wdata;
        case (op_funct3[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                byte_en  = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{op_wdata[15:0]}};
            end
            2'b10: begin
                byte_en  = 4'b1111;
                wr_lanes = op_wdata;
            end
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        rd_word = mem[mem_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (op_funct3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_val = {16'd0, rd_half};
            3'b010:  load_val = rd_word;
            default: load_val = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= 32'd0;
            req_funct3 <= 3'd0;
            rdata_o    <= 32'd0;
            err_o      <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                req_we     <= we_i;
                req_addr   <= addr_i;
                req_wdata  <= wdata_i;
                req_funct3 <= funct3_i;
            end
            if (enter_resp) begin
                err_o   <= access_err;
                rdata_o <= (access_err || op_we) ? 32'd0 : load_val;
            end else begin
                err_o   <= 1'b0;
                rdata_o <= 32'd0;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; contents survive rst
    // and a resettable array would not map onto a RAM.
    always_ff @(posedge clk) begin
        if (commit && op_we && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[mem_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: main instance with 2 wait states, a second with 0.
// Honours DMEM_ALIGN_CHECK_EN for the misaligned-access expectations.
module tb_dmem_responder;

    localparam int WS    = 2;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req, we, ready, rvalid, err, busy;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  f3;

    logic        z_req, z_we, z_ready, z_rvalid, z_err, z_busy;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [2:0]  z_f3;

    dmem_responder #(.WAIT_STATES(WS), .MEM_DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .funct3_i(f3), .ready_o(ready), .rvalid_o(rvalid), .rdata_o(rdata),
        .err_o(err), .busy_o(busy)
    );

    dmem_responder #(.WAIT_STATES(0), .MEM_DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32)) u_dut_z (
        .clk(clk), .rst(rst), .req_i(z_req), .we_i(z_we), .addr_i(z_addr), .wdata_i(z_wdata),
        .funct3_i(z_f3), .ready_o(z_ready), .rvalid_o(z_rvalid), .rdata_o(z_rdata),
        .err_o(z_err), .busy_o(z_busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mdl [DEPTH];
    int          n_acc;
    int          last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: access size from funct3[1:0], offset rounded down to the size.
    function automatic void model(input logic m_we, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [2:0] f, output logic e, output logic [31:0] d);
        int unsigned idx;
        int          nbytes;
        int          off;
        logic [31:0] w;
        logic [31:0] mask;
        idx    = a >> 2;
        nbytes = 1 << f[1:0];
        off    = (int'(a[1:0]) / nbytes) * nbytes;
        e = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (m_we && f >= 3'd4) || (idx >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
        if (nbytes > 1 && (int'(a[1:0]) % nbytes) != 0) e = 1'b1;
`endif
        d = 32'd0;
        if (e) return;
        w = mdl[idx];
        if (m_we) begin
            for (int i = 0; i < nbytes; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
            mdl[idx] = w;
        end else begin
            d = w >> (8 * off);
            if (nbytes < 4) begin
                mask = (32'd1 << (8 * nbytes)) - 32'd1;
                d = d & mask;
                if (!f[2] && d[8*nbytes-1]) d = d | ~mask;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && rvalid) begin
            if (sb.size() == 0) begin
                check("rvalid_without_request", {31'd0, rvalid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rdata", rdata, mon_e.data);
                check("err", {31'd0, err}, {31'd0, mon_e.err});
                check("latency", 32'(cyc - mon_e.acc), 32'(WS + 1));
                check("ready_in_resp", {31'd0, ready}, 32'd0);
            end
        end
    end

    task automatic issue_raw(input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] f, input logic e_err, input logic [31:0] e_data);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd; f3 = f;
        for (int t = 0; t < 50 && !ready; t++) @(negedge clk);
        if (!ready) check("accept_timeout", {31'd0, ready}, 32'd1);
        else sb.push_back('{err: e_err, data: e_data, acc: cyc});
    endtask

    task automatic op(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f);
        logic        e;
        logic [31:0] d;
        model(w, a, wd, f, e, d);
        issue_raw(w, a, wd, f, e, d);
    endtask

    task automatic op_exp(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f, input logic e_err, input logic [31:0] e_data);
        logic        e;
        logic [31:0] d;
        model(w, a, wd, f, e, d);
        issue_raw(w, a, wd, f, e_err, e_data);
    endtask

    task automatic drain();
        @(negedge clk);
        req = 1'b0;
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
        check("drain_pending", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; f3 = 3'd0;
        z_req = 1'b0; z_we = 1'b0; z_addr = 32'd0; z_wdata = 32'd0; z_f3 = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_rvalid", {31'd0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Zero wait states, request held high: one accept every two cycles.
        @(negedge clk);
        z_req = 1'b1; z_we = 1'b1; z_addr = 32'h40; z_wdata = 32'h55; z_f3 = 3'd2;
        n_acc = 0; last_acc = -1;
        for (int i = 0; i < 12; i++) begin
            if (z_rvalid) begin
                check("z_ready_in_resp", {31'd0, z_ready}, 32'd0);
                check("z_err", {31'd0, z_err}, 32'd0);
                check("z_rdata_store", z_rdata, 32'd0);
                check("z_latency", 32'(cyc - last_acc), 32'd1);
            end
            if (z_ready) begin
                if (last_acc >= 0) check("z_accept_gap", 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
        end
        z_req = 1'b0;
        check("z_accept_count", 32'(n_acc), 32'd6);

        op_exp(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0);
        op_exp(1'b0, 32'h10, 32'h0,        3'd2, 1'b0, 32'hDEADBEEF);
        op_exp(1'b1, 32'h10, 32'h11223344, 3'd2, 1'b0, 32'h0);
        op_exp(1'b1, 32'h11, 32'h0000005A, 3'd0, 1'b0, 32'h0);
        op_exp(1'b0, 32'h10, 32'h0,        3'd2, 1'b0, 32'h11225A44);
        op_exp(1'b0, 32'h13, 32'h0,        3'd0, 1'b0, 32'h00000011);
        op_exp(1'b0, 32'h12, 32'h0,        3'd4, 1'b0, 32'h00000022);
        op_exp(1'b0, 32'h11, 32'h0,        3'd0, 1'b0, 32'h0000005A);
        op_exp(1'b1, 32'h14, 32'h0,        3'd2, 1'b0, 32'h0);
        op_exp(1'b1, 32'h17, 32'hFFFFFF80, 3'd0, 1'b0, 32'h0);
        op_exp(1'b0, 32'h17, 32'h0,        3'd0, 1'b0, 32'hFFFFFF80);
        op_exp(1'b0, 32'h17, 32'h0,        3'd4, 1'b0, 32'h00000080);
        op_exp(1'b0, 32'h14, 32'h0,        3'd2, 1'b0, 32'h80000000);
        op_exp(1'b1, 32'h20, 32'h0,        3'd2, 1'b0, 32'h0);
        op_exp(1'b1, 32'h22, 32'h00008001, 3'd1, 1'b0, 32'h0);
        op_exp(1'b0, 32'h22, 32'h0,        3'd1, 1'b0, 32'hFFFF8001);
        op_exp(1'b0, 32'h22, 32'h0,        3'd5, 1'b0, 32'h00008001);
        op_exp(1'b0, 32'h20, 32'h0,        3'd2, 1'b0, 32'h80010000);
        // Rejected requests: illegal funct3, out-of-range index, illegal store funct3.
        op_exp(1'b0, 32'h10,   32'h0,        3'd3, 1'b1, 32'h0);
        op_exp(1'b0, 32'h1000, 32'h0,        3'd2, 1'b1, 32'h0);
        op_exp(1'b1, 32'h10,   32'hFFFFFFFF, 3'd4, 1'b1, 32'h0);
        op_exp(1'b1, 32'h10,   32'hFFFFFFFF, 3'd3, 1'b1, 32'h0);
        op_exp(1'b1, 32'h1000, 32'hFFFFFFFF, 3'd2, 1'b1, 32'h0);
        op_exp(1'b0, 32'h10,   32'h0,        3'd6, 1'b1, 32'h0);
        op_exp(1'b0, 32'h10,   32'h0,        3'd7, 1'b1, 32'h0);
        op_exp(1'b0, 32'h10,   32'h0,        3'd2, 1'b0, 32'h11225A44);
        op_exp(1'b1, 32'hFFC,  32'h12345678, 3'd2, 1'b0, 32'h0);
        op_exp(1'b0, 32'hFFC,  32'h0,        3'd2, 1'b0, 32'h12345678);
        drain();

        // Reset during WAIT drops the store.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEBABE; f3 = 3'd2;
        for (int t = 0; t < 50 && !ready; t++) @(negedge clk);
        check("rst_test_accept", {31'd0, ready}, 32'd1);
        @(negedge clk);
        check("busy_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        req = 1'b0;
        #1;
        check("busy_during_rst", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("ready_after_release", {31'd0, ready}, 32'd1);
        check("rvalid_after_release", {31'd0, rvalid}, 32'd0);
        op_exp(1'b0, 32'h20, 32'h0, 3'd2, 1'b0, 32'h80010000);
        drain();

`ifdef DMEM_ALIGN_CHECK_EN
        op_exp(1'b0, 32'h22, 32'h0,    3'd2, 1'b1, 32'h0);
        op_exp(1'b0, 32'h23, 32'h0,    3'd1, 1'b1, 32'h0);
        op_exp(1'b1, 32'h21, 32'h1234, 3'd1, 1'b1, 32'h0);
        op_exp(1'b0, 32'h20, 32'h0,    3'd2, 1'b0, 32'h80010000);
`else
        op_exp(1'b0, 32'h22, 32'h0,    3'd2, 1'b0, 32'h80010000);
        op_exp(1'b0, 32'h23, 32'h0,    3'd1, 1'b0, 32'hFFFF8001);
        op_exp(1'b1, 32'h21, 32'h1234, 3'd1, 1'b0, 32'h0);
        op_exp(1'b0, 32'h20, 32'h0,    3'd2, 1'b0, 32'h80011234);
`endif

        // Random traffic over four initialised words plus occasional out-of-range.
        for (int i = 0; i < 4; i++) op(1'b1, 32'h100 + 32'(4 * i), $urandom, 3'd2);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 15));
            else a = 32'h100 + 32'($urandom_range(0, 15));
            op(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
